// File: rtl/cr16_ctrl_pkg.sv
// Shared types and encodings for the CR16 multicycle control path.
// Holds the FSM state, instruction field and class encodings, and the registered control bundles.
package cr16_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned DISP_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_PC     = 3'd4
  } state_e;

  // Major opcodes, IR[15:12]
  localparam logic [FIELD_W-1:0] OP_REG   = 4'h0;
  localparam logic [FIELD_W-1:0] OP_MEMJ  = 4'h4;
  localparam logic [FIELD_W-1:0] OP_CMPI  = 4'hB;
  localparam logic [FIELD_W-1:0] OP_BCOND = 4'hC;
  localparam logic [FIELD_W-1:0] OP_RSVD  = 4'hF;

  // Extended opcodes, IR[7:4]
  localparam logic [FIELD_W-1:0] EXT_LOAD  = 4'h0;
  localparam logic [FIELD_W-1:0] EXT_STOR  = 4'h4;
  localparam logic [FIELD_W-1:0] EXT_JAL   = 4'h8;
  localparam logic [FIELD_W-1:0] EXT_CMP   = 4'hB;
  localparam logic [FIELD_W-1:0] EXT_JCOND = 4'hC;

  // Condition codes, IR[11:8]
  localparam logic [FIELD_W-1:0] COND_EQ = 4'h0;
  localparam logic [FIELD_W-1:0] COND_NE = 4'h1;
  localparam logic [FIELD_W-1:0] COND_CS = 4'h2;
  localparam logic [FIELD_W-1:0] COND_CC = 4'h3;
  localparam logic [FIELD_W-1:0] COND_HI = 4'h4;
  localparam logic [FIELD_W-1:0] COND_LS = 4'h5;
  localparam logic [FIELD_W-1:0] COND_GT = 4'h6;
  localparam logic [FIELD_W-1:0] COND_LE = 4'h7;
  localparam logic [FIELD_W-1:0] COND_FS = 4'h8;
  localparam logic [FIELD_W-1:0] COND_FC = 4'h9;
  localparam logic [FIELD_W-1:0] COND_LO = 4'hA;
  localparam logic [FIELD_W-1:0] COND_HS = 4'hB;
  localparam logic [FIELD_W-1:0] COND_LT = 4'hC;
  localparam logic [FIELD_W-1:0] COND_GE = 4'hD;
  localparam logic [FIELD_W-1:0] COND_UC = 4'hE;
  localparam logic [FIELD_W-1:0] COND_NV = 4'hF;

  // PSR flag bit positions within {C,L,F,Z,N}
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [1:0] {
    WSRC_ALU  = 2'd0,
    WSRC_MEM  = 2'd1,
    WSRC_LINK = 2'd2
  } rf_wsrc_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_CMP   = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STOR  = 3'd4,
    CLS_JAL   = 3'd5,
    CLS_BCOND = 3'd6,
    CLS_JCOND = 3'd7
  } instr_cls_e;

  typedef struct packed {
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] cond;
    logic [FIELD_W-1:0] ext;
  } ir_fields_t;

  typedef struct packed {
    logic     ir_load;
    logic     mem_read;
    logic     mem_write;
    logic     mem_addr_src;
    logic     alu_exec;
    logic     flags_write;
    logic     rf_write;
    rf_wsrc_e rf_wsrc;
    logic     pc_enable;
    logic     load_wait;
  } ctrl_t;

  typedef struct packed {
    logic select;
    logic displace;
    logic src;
  } pc_sel_t;

  // Map the decoded IR fields onto an execution class.
  function automatic instr_cls_e classify(input ir_fields_t ir);
    instr_cls_e cls;
    cls = CLS_NOP;
    case (ir.op)
      OP_REG:   cls = (ir.ext == EXT_CMP) ? CLS_CMP : CLS_ALU;
      OP_MEMJ: begin
        case (ir.ext)
          EXT_LOAD:  cls = CLS_LOAD;
          EXT_STOR:  cls = CLS_STOR;
          EXT_JAL:   cls = CLS_JAL;
          EXT_JCOND: cls = CLS_JCOND;
          default:   cls = CLS_NOP;
        endcase
      end
      OP_CMPI:  cls = CLS_CMP;
      OP_BCOND: cls = CLS_BCOND;
      OP_RSVD:  cls = CLS_NOP;
      default:  cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: condition code and PSR flags in, taken out.
module cond_eval
  import cr16_ctrl_pkg::*;
(
  input  logic [FIELD_W-1:0] cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_EQ: taken_c = flags[FLAG_Z];
      COND_NE: taken_c = ~flags[FLAG_Z];
      COND_CS: taken_c = flags[FLAG_C];
      COND_CC: taken_c = ~flags[FLAG_C];
      COND_HI: taken_c = flags[FLAG_L];
      COND_LS: taken_c = ~flags[FLAG_L];
      COND_GT: taken_c = flags[FLAG_N];
      COND_LE: taken_c = ~flags[FLAG_N];
      COND_FS: taken_c = flags[FLAG_F];
      COND_FC: taken_c = ~flags[FLAG_F];
      COND_LO: taken_c = ~flags[FLAG_L] & ~flags[FLAG_Z];
      COND_HS: taken_c = flags[FLAG_L] | flags[FLAG_Z];
      COND_LT: taken_c = ~flags[FLAG_N] & ~flags[FLAG_Z];
      COND_GE: taken_c = flags[FLAG_N] | flags[FLAG_Z];
      COND_UC: taken_c = 1'b1;
      COND_NV: taken_c = 1'b0;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// CR16 fetch/decode/execute sequencer: drives memory strobes, datapath write enables
// and the pc enable pulse with its address selects.
module pc_sequencer
  import cr16_ctrl_pkg::*;
#(
  parameter int unsigned P_ADDRESS_WIDTH = 16,
  parameter int unsigned P_INSTR_WIDTH   = 16
) (
  input  logic                     I_CLK,
  input  logic                     I_NRESET,
  input  logic [P_INSTR_WIDTH-1:0] I_INSTR,
  input  logic                     I_MEM_READY,
  input  logic [FLAGS_W-1:0]       I_FLAGS,
  output logic                     O_IR_LOAD,
  output logic                     O_MEM_READ,
  output logic                     O_MEM_WRITE,
  output logic                     O_MEM_ADDR_SRC,
  output logic                     O_ALU_EXEC,
  output logic                     O_FLAGS_WRITE,
  output logic                     O_RF_WRITE,
  output logic [1:0]               O_RF_WSRC,
  output logic                     O_PC_ENABLE,
  output logic                     O_PC_ADDR_SELECT,
  output logic                     O_PC_ADDR_DISPLACE,
  output logic                     O_PC_ADDR_INCREMENT,
  output logic                     O_PC_ADDR_SRC,
  output logic [STATE_W-1:0]       O_STATE
);

  // The address mux must hold a sign-extended displacement; the decoder assumes 16-bit words.
  if (P_ADDRESS_WIDTH < DISP_W || P_INSTR_WIDTH != 16) begin : g_width_check
    $error("pc_sequencer: unsupported P_ADDRESS_WIDTH/P_INSTR_WIDTH");
  end

  state_e     state_q, state_d;
  ir_fields_t ir_q;
  instr_cls_e cls_c;
  ctrl_t      ctrl_q, ctrl_d;
  pc_sel_t    sel_q, sel_d;
  logic       taken_c;
  logic       fetch_done_c;
  logic       ir_unused;

  assign ir_unused    = ^I_INSTR[3:0];
  assign cls_c        = classify(ir_q);
  assign fetch_done_c = (state_q == S_FETCH) && ctrl_q.mem_read && I_MEM_READY;

  cond_eval u_cond_eval (
    .cond    (ir_q.cond),
    .flags   (I_FLAGS),
    .taken_c (taken_c)
  );

  // State register
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_done_c) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (cls_c == CLS_LOAD || cls_c == CLS_STOR) ? S_MEM : S_PC;
      S_MEM:    if (I_MEM_READY) state_d = S_PC;
      S_PC:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control decode of the state being entered, so the registered outputs line up with O_STATE.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.ir_load = fetch_done_c;
    case (state_d)
      S_FETCH: ctrl_d.mem_read = 1'b1;
      S_EXEC: begin
        case (cls_c)
          CLS_ALU: begin
            ctrl_d.alu_exec    = 1'b1;
            ctrl_d.flags_write = 1'b1;
            ctrl_d.rf_write    = 1'b1;
          end
          CLS_CMP: begin
            ctrl_d.alu_exec    = 1'b1;
            ctrl_d.flags_write = 1'b1;
          end
          CLS_JAL: begin
            ctrl_d.rf_write = 1'b1;
            ctrl_d.rf_wsrc  = WSRC_LINK;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_d.mem_addr_src = 1'b1;
        ctrl_d.mem_read     = (cls_c == CLS_LOAD);
        ctrl_d.mem_write    = (cls_c == CLS_STOR);
        ctrl_d.load_wait    = (cls_c == CLS_LOAD);
        ctrl_d.rf_wsrc      = (cls_c == CLS_LOAD) ? WSRC_MEM : WSRC_ALU;
      end
      S_PC:    ctrl_d.pc_enable = 1'b1;
      default: ;
    endcase
  end

  // PC selects resolve as the instruction enters execute, a full cycle ahead of the enable edge.
  always_comb begin
    sel_d = sel_q;
    if (state_q == S_DECODE) begin
      sel_d = '0;
      case (cls_c)
        CLS_BCOND: begin
          sel_d.select   = taken_c;
          sel_d.displace = taken_c;
        end
        CLS_JCOND: begin
          sel_d.select = taken_c;
          sel_d.src    = taken_c;
        end
        CLS_JAL: begin
          sel_d.select = 1'b1;
          sel_d.src    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      ctrl_q <= '0;
      sel_q  <= '0;
      ir_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      sel_q  <= sel_d;
      if (fetch_done_c) ir_q <= ir_fields_t'(I_INSTR[15:4]);
    end
  end

  assign O_IR_LOAD           = ctrl_q.ir_load;
  assign O_MEM_READ          = ctrl_q.mem_read;
  assign O_MEM_WRITE         = ctrl_q.mem_write;
  assign O_MEM_ADDR_SRC      = ctrl_q.mem_addr_src;
  assign O_ALU_EXEC          = ctrl_q.alu_exec;
  assign O_FLAGS_WRITE       = ctrl_q.flags_write;
  // Load data is only valid alongside I_MEM_READY, so the write enable is qualified by it.
  assign O_RF_WRITE          = ctrl_q.rf_write | (ctrl_q.load_wait & I_MEM_READY);
  assign O_RF_WSRC           = ctrl_q.rf_wsrc;
  assign O_PC_ENABLE         = ctrl_q.pc_enable;
  assign O_PC_ADDR_SELECT    = sel_q.select;
  assign O_PC_ADDR_DISPLACE  = sel_q.displace;
  assign O_PC_ADDR_INCREMENT = 1'b0;
  assign O_PC_ADDR_SRC       = sel_q.src;
  assign O_STATE             = state_q;

endmodule
